ib_lut_load_ctrl: RTL and testbench
===================================

Name: ib_lut_load_ctrl

Overview:
- Sequences loading of information-bottleneck LUT contents into BANK_NUM simple-dual-port distributed LUT banks.
- Accepts a valid/ready stream of QUAN_SIZE-bit LUT entries, generates a registered write address, write data and a one-hot per-bank write strobe, and tracks which banks hold a complete table.
- Sits between the LUT configuration source and the bank array. Decoder read-side logic gates LUT reads with bank_valid_o.

Parameters:
- QUAN_SIZE, 3, bit width of one LUT entry (quantised message).
- PAGE_NUM, 16, entries per bank.
- ADDR_BITWIDTH, 4, page address width; must satisfy 2^ADDR_BITWIDTH >= PAGE_NUM.
- BANK_NUM, 4, number of LUT banks loaded sequentially.
- BANK_BITWIDTH, 2, bank index width; must satisfy 2^BANK_BITWIDTH >= BANK_NUM.

Ports:
- write_clk  in  1  single clock for the block and the bank write ports.
- rstn  in  1  synchronous active-low reset, sampled on the write_clk rising edge.
- load_start_i  in  1  one-cycle request to (re)load all banks.
- abort_i  in  1  terminates a load in progress.
- lut_data_i  in  QUAN_SIZE  incoming LUT entry.
- lut_valid_i  in  1  lut_data_i is valid.
- lut_ready_o  out  1  controller accepts an entry this cycle.
- write_data_o  out  QUAN_SIZE  data to all bank write_data inputs.
- write_addr_o  out  ADDR_BITWIDTH  page address to all bank write_addr inputs.
- we_o  out  BANK_NUM  one-hot bank write enable.
- bank_valid_o  out  BANK_NUM  bank b holds a completely loaded table.
- busy_o  out  1  load in progress.
- done_o  out  1  one-cycle pulse when all banks are loaded.
- start_ignored_o  out  1  one-cycle pulse when load_start_i arrives while busy.

Behaviour:
- Reset (rstn=0 at a clock edge):
  - State=IDLE; all outputs 0, including bank_valid_o; page and bank counters 0.
  - A reset mid-load discards the load; no further we_o is issued.
- States and transitions:
  - IDLE: lut_ready_o=0, busy_o=0. On load_start_i=1: go to LOAD, clear counters, clear bank_valid_o to all-zero in the next cycle.
  - LOAD: busy_o=1, lut_ready_o=1. A handshake is lut_valid_i&lut_ready_o. Each handshake captures lut_data_i.
  - LOAD exit on last entry: the handshake at bank=BANK_NUM-1, page=PAGE_NUM-1 goes to DONE.
  - LOAD exit on abort: abort_i=1 returns to IDLE. abort_i has priority over a same-cycle handshake; that entry is not written.
  - DONE: busy_o=0, lut_ready_o=0, done_o=1 for exactly one cycle, then IDLE.
- Write timing: registered, latency 1. After a handshake in cycle N, in cycle N+1 the outputs are:
  - write_data_o = captured data;
  - write_addr_o = current page;
  - we_o = one-hot of current bank.
  - Outside that cycle we_o=0. write_data_o and write_addr_o hold their last values.
- Counters: the page counter increments per handshake. At PAGE_NUM-1 it wraps to 0 and the bank counter increments. Counters never exceed their maxima.
- bank_valid_o[b] rises in the cycle after the we_o strobe for bank b, page PAGE_NUM-1. It stays high until the next accepted load_start_i or reset.
- Abort: banks already completed keep their bank_valid_o bits; the partially loaded bank stays invalid.
- done_o: asserted in the same cycle as the final bank_valid_o bit rises, i.e. two cycles after the last handshake.
- load_start_i in LOAD or DONE is ignored and pulses start_ignored_o for one cycle.
- Simultaneous load_start_i and abort_i in LOAD: abort wins and start_ignored_o pulses. Restart requires a new load_start_i.
- lut_valid_i in IDLE or DONE: ignored (ready=0).

Decomposition:
- Shared package ib_lut_pkg holds:
  - the state enum (IDLE, LOAD, DONE);
  - QUAN_SIZE, PAGE_NUM, ADDR_BITWIDTH, BANK_NUM, BANK_BITWIDTH defaults;
  - a function for the one-hot bank decode.
- One natural sub-module: ib_lut_addr_gen, holding the page/bank counters with wrap and a last-entry flag.
- The FSM, capture register and bank_valid tracking stay in the top module.

Test Plan:
- Reset mid-load: rstn=0 after 5 handshakes.
  - Next cycle: we_o=0, busy_o=0, bank_valid_o=0.
  - Subsequent lut_valid_i is not accepted.
- Full load with defaults: load_start_i pulse, then 64 back-to-back entries with data=i%8.
  - we_o=0001 on entries 0..15 with addr 0..15, then 0010, 0100, 1000.
  - bank_valid_o steps 0001, 0011, 0111, 1111.
  - done_o pulses once, 2 cycles after entry 63.
- Bubbly source: lut_valid_i toggles every other cycle.
  - Exactly 64 we_o strobes.
  - Addresses 0..15 per bank with no gaps or duplicates; data matches the stream.
- Abort at entry 20, same cycle as a valid handshake.
  - Only 20 strobes total; bank_valid_o=0001; busy_o=0 next cycle.
  - Entry 20 is not written.
- Restart: load_start_i during LOAD gives start_ignored_o=1 and the load continues unaffected.
  - After done_o, a second load_start_i clears bank_valid_o to 0000.
  - The second load completes with bank_valid_o=1111.
- Parameter corner PAGE_NUM=5, ADDR_BITWIDTH=3, BANK_NUM=3:
  - Page counter wraps 4->0.
  - 15 strobes in total; done_o pulses once.

Source files
------------

// File: rtl/ib_lut_pkg.sv
// Shared types, default geometry and the one-hot bank decode for the IB LUT loader.
package ib_lut_pkg;

  localparam int IB_QUAN_SIZE     = 3;
  localparam int IB_PAGE_NUM      = 16;
  localparam int IB_ADDR_BITWIDTH = 4;
  localparam int IB_BANK_NUM      = 4;
  localparam int IB_BANK_BITWIDTH = 2;

  // Decode is done at a fixed maximum width; callers cast down to BANK_NUM.
  localparam int ONEHOT_MAX      = 32;
  localparam int ONEHOT_IDX_BITS = 5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic logic [ONEHOT_MAX-1:0] bank_onehot(input logic [ONEHOT_IDX_BITS-1:0] idx);
    logic [ONEHOT_MAX-1:0] oh;
    oh      = '0;
    oh[idx] = 1'b1;
    return oh;
  endfunction

endpackage

// File: rtl/ib_lut_addr_gen.sv
// Page/bank write counters for the LUT loader; page wraps into the next bank.
// Latency: counters update on the edge of each accepted entry.
// Backpressure: none of its own; advances only when the parent accepts an entry.
module ib_lut_addr_gen
  import ib_lut_pkg::*;
#(
  parameter int PAGE_NUM      = IB_PAGE_NUM,
  parameter int ADDR_BITWIDTH = IB_ADDR_BITWIDTH,
  parameter int BANK_NUM      = IB_BANK_NUM,
  parameter int BANK_BITWIDTH = IB_BANK_BITWIDTH
) (
  input  logic                     write_clk,
  input  logic                     rstn,
  input  logic                     clr,
  input  logic                     adv,
  output logic [ADDR_BITWIDTH-1:0] page,
  output logic [BANK_BITWIDTH-1:0] bank,
  output logic                     page_last,
  output logic                     last
);

  localparam logic [ADDR_BITWIDTH-1:0] PAGE_LAST = ADDR_BITWIDTH'(PAGE_NUM - 1);
  localparam logic [BANK_BITWIDTH-1:0] BANK_LAST = BANK_BITWIDTH'(BANK_NUM - 1);

  assign page_last = (page == PAGE_LAST);
  assign last      = page_last && (bank == BANK_LAST);

  always_ff @(posedge write_clk) begin
    if (!rstn || clr) begin
      page <= '0;
      bank <= '0;
    end else if (adv) begin
      if (page_last) begin
        page <= '0;
        // Bank saturates on the final entry so it never runs past the array.
        if (bank != BANK_LAST) begin
          bank <= bank + 1'b1;
        end
      end else begin
        page <= page + 1'b1;
      end
    end
  end

endmodule

// File: rtl/ib_lut_load_ctrl.sv
// Loads a valid/ready stream of LUT entries into BANK_NUM banks and tracks complete banks.
// Latency: bank write strobe 1 cycle after handshake; bank_valid/done 2 cycles after.
// Backpressure: ready only while loading; no internal buffering, source stalls otherwise.
module ib_lut_load_ctrl
  import ib_lut_pkg::*;
#(
  parameter int QUAN_SIZE     = IB_QUAN_SIZE,
  parameter int PAGE_NUM      = IB_PAGE_NUM,
  parameter int ADDR_BITWIDTH = IB_ADDR_BITWIDTH,
  parameter int BANK_NUM      = IB_BANK_NUM,
  parameter int BANK_BITWIDTH = IB_BANK_BITWIDTH
) (
  input  logic                     write_clk,
  input  logic                     rstn,
  input  logic                     load_start_i,
  input  logic                     abort_i,
  input  logic [QUAN_SIZE-1:0]     lut_data_i,
  input  logic                     lut_valid_i,
  output logic                     lut_ready_o,
  output logic [QUAN_SIZE-1:0]     write_data_o,
  output logic [ADDR_BITWIDTH-1:0] write_addr_o,
  output logic [BANK_NUM-1:0]      we_o,
  output logic [BANK_NUM-1:0]      bank_valid_o,
  output logic                     busy_o,
  output logic                     done_o,
  output logic                     start_ignored_o
);

  state_t                   state, state_nxt;
  logic                     hs;
  logic                     start_acc;
  logic                     page_last;
  logic                     last;
  logic                     wr_page_last;
  logic [ADDR_BITWIDTH-1:0] page;
  logic [BANK_BITWIDTH-1:0] bank;

  // Abort outranks a same-cycle handshake, so that entry is never written.
  assign hs        = lut_ready_o && lut_valid_i && !abort_i;
  assign start_acc = (state == IDLE) && load_start_i;

  ib_lut_addr_gen #(
    .PAGE_NUM      (PAGE_NUM),
    .ADDR_BITWIDTH (ADDR_BITWIDTH),
    .BANK_NUM      (BANK_NUM),
    .BANK_BITWIDTH (BANK_BITWIDTH)
  ) u_addr_gen (
    .write_clk (write_clk),
    .rstn      (rstn),
    .clr       (start_acc),
    .adv       (hs),
    .page      (page),
    .bank      (bank),
    .page_last (page_last),
    .last      (last)
  );

  always_ff @(posedge write_clk) begin
    if (!rstn) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    lut_ready_o = 1'b0;
    busy_o      = 1'b0;
    unique case (state)
      IDLE: begin
        if (load_start_i) begin
          state_nxt = LOAD;
        end
      end
      LOAD: begin
        lut_ready_o = 1'b1;
        busy_o      = 1'b1;
        if (abort_i) begin
          state_nxt = IDLE;
        end else if (lut_valid_i && last) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge write_clk) begin
    if (!rstn) begin
      write_data_o <= '0;
      write_addr_o <= '0;
      we_o         <= '0;
      wr_page_last <= 1'b0;
    end else begin
      we_o         <= '0;
      wr_page_last <= 1'b0;
      if (hs) begin
        write_data_o <= lut_data_i;
        write_addr_o <= page;
        we_o         <= BANK_NUM'(bank_onehot(ONEHOT_IDX_BITS'(bank)));
        wr_page_last <= page_last;
      end
    end
  end

  always_ff @(posedge write_clk) begin
    if (!rstn) begin
      bank_valid_o    <= '0;
      done_o          <= 1'b0;
      start_ignored_o <= 1'b0;
    end else begin
      done_o          <= (state == DONE);
      start_ignored_o <= load_start_i && (state != IDLE);
      // A bank becomes valid once the strobe for its final page has gone out.
      if (start_acc) begin
        bank_valid_o <= '0;
      end else if (wr_page_last) begin
        bank_valid_o <= bank_valid_o | we_o;
      end
    end
  end

endmodule

// File: tb/tb_ib_lut_load_ctrl.sv
// Scoreboard bench for ib_lut_load_ctrl: default geometry plus a 5-page/3-bank corner instance.
module tb_ib_lut_load_ctrl;

  typedef struct {
    logic [3:0] we;
    logic [3:0] addr;
    logic [2:0] data;
  } exp_t;

  logic write_clk = 1'b0;
  always #5 write_clk = ~write_clk;

  logic rstn;

  logic       ls0, ab0, v0, rdy0, busy0, done0, si0;
  logic [2:0] dat0, wd0;
  logic [3:0] wa0, we0, bv0;

  logic       ls1, ab1, v1, rdy1, busy1, done1, si1;
  logic [2:0] dat1, wd1, wa1, we1, bv1;

  exp_t q0[$];
  exp_t q1[$];
  int   nvec = 0;
  int   nerr = 0;
  int   str0 = 0, str1 = 0, dn0 = 0, dn1 = 0;

  ib_lut_load_ctrl u_dut0 (
    .write_clk       (write_clk),
    .rstn            (rstn),
    .load_start_i    (ls0),
    .abort_i         (ab0),
    .lut_data_i      (dat0),
    .lut_valid_i     (v0),
    .lut_ready_o     (rdy0),
    .write_data_o    (wd0),
    .write_addr_o    (wa0),
    .we_o            (we0),
    .bank_valid_o    (bv0),
    .busy_o          (busy0),
    .done_o          (done0),
    .start_ignored_o (si0)
  );

  ib_lut_load_ctrl #(
    .PAGE_NUM      (5),
    .ADDR_BITWIDTH (3),
    .BANK_NUM      (3),
    .BANK_BITWIDTH (2)
  ) u_dut1 (
    .write_clk       (write_clk),
    .rstn            (rstn),
    .load_start_i    (ls1),
    .abort_i         (ab1),
    .lut_data_i      (dat1),
    .lut_valid_i     (v1),
    .lut_ready_o     (rdy1),
    .write_data_o    (wd1),
    .write_addr_o    (wa1),
    .we_o            (we1),
    .bank_valid_o    (bv1),
    .busy_o          (busy1),
    .done_o          (done1),
    .start_ignored_o (si1)
  );

  // Monitors: pop the scoreboard whenever a write strobe is presented.
  always @(negedge write_clk) begin
    exp_t e;
    if (we0 != 4'd0) begin
      str0++;
      nvec++;
      if (q0.size() == 0) begin
        nerr++;
        $display("FAIL wr0_unexpected got we=%b addr=%0d data=%0d, none expected", we0, wa0, wd0);
      end else begin
        e = q0.pop_front();
        if ({we0, wa0, wd0} !== {e.we, e.addr, e.data}) begin
          nerr++;
          $display("FAIL wr0 got we=%b addr=%0d data=%0d want we=%b addr=%0d data=%0d",
                   we0, wa0, wd0, e.we, e.addr, e.data);
        end
      end
    end
    if (done0) dn0++;
  end

  always @(negedge write_clk) begin
    exp_t e;
    if (we1 != 3'd0) begin
      str1++;
      nvec++;
      if (q1.size() == 0) begin
        nerr++;
        $display("FAIL wr1_unexpected got we=%b addr=%0d data=%0d, none expected", we1, wa1, wd1);
      end else begin
        e = q1.pop_front();
        if ({4'(we1), 4'(wa1), wd1} !== {e.we, e.addr, e.data}) begin
          nerr++;
          $display("FAIL wr1 got we=%b addr=%0d data=%0d want we=%b addr=%0d data=%0d",
                   we1, wa1, wd1, e.we, e.addr, e.data);
        end
      end
    end
    if (done1) dn1++;
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge write_clk);
    #1;
  endtask

  task automatic start(input int dut);
    if (dut == 0) ls0 = 1'b1; else ls1 = 1'b1;
    tick();
    ls0 = 1'b0;
    ls1 = 1'b0;
  endtask

  // Issue one entry; the DUT is known to be in LOAD, so it will be accepted.
  task automatic send(input int dut, input int idx, input logic [2:0] dat, input int gap,
                      input logic with_start);
    exp_t e;
    int   pg;
    pg     = (dut == 0) ? 16 : 5;
    e.we   = 4'(1 << (idx / pg));
    e.addr = 4'(idx % pg);
    e.data = dat;
    if (dut == 0) begin
      v0 = 1'b1; dat0 = dat; ls0 = with_start; q0.push_back(e);
    end else begin
      v1 = 1'b1; dat1 = dat; q1.push_back(e);
    end
    tick();
    v0 = 1'b0; v1 = 1'b0; ls0 = 1'b0;
    repeat (gap) tick();
  endtask

  initial begin
    int s;
    rstn = 1'b0;
    ls0 = 0; ab0 = 0; v0 = 0; dat0 = '0;
    ls1 = 0; ab1 = 0; v1 = 0; dat1 = '0;
    tick();
    tick();
    check("rst_we", we0, 4'd0);
    check("rst_bank_valid", bv0, 4'd0);
    check("rst_busy_ready_done_si", {busy0, rdy0, done0, si0}, 4'd0);
    rstn = 1'b1;
    tick();

    // Reset in the middle of a load.
    start(0);
    check("load_busy", busy0, 1'b1);
    for (int i = 0; i < 5; i++) send(0, i, 3'(i + 2), 0, 1'b0);
    rstn = 1'b0;
    tick();
    check("midrst_we", we0, 4'd0);
    check("midrst_busy", busy0, 1'b0);
    check("midrst_bank_valid", bv0, 4'd0);
    rstn = 1'b1;
    s = str0;
    v0 = 1'b1;
    tick();
    check("midrst_ready", rdy0, 1'b0);
    tick();
    tick();
    v0 = 1'b0;
    tick();
    check("midrst_no_strobes", str0 - s, 0);

    // Full back-to-back load.
    start(0);
    s = str0;
    for (int i = 0; i < 64; i++) begin
      send(0, i, 3'(i % 8), 0, 1'b0);
      if (i % 16 == 0 && i > 0) check($sformatf("bv_step_%0d", i), bv0, (1 << (i / 16)) - 1);
    end
    check("full_pre_done", {busy0, done0}, 2'b00);
    check("full_bv_3", bv0, 4'b0111);
    tick();
    check("full_done", done0, 1'b1);
    check("full_bv_all", bv0, 4'b1111);
    tick();
    check("full_done_pulse", done0, 1'b0);
    check("full_strobes", str0 - s, 64);
    check("full_done_count", dn0, 1);

    // Bubbly source.
    start(0);
    s = str0;
    for (int i = 0; i < 64; i++) send(0, i, 3'((i * 3 + 1) % 8), 1, 1'b0);
    tick();
    check("bubbly_strobes", str0 - s, 64);
    check("bubbly_bv", bv0, 4'b1111);
    check("bubbly_done_count", dn0, 2);

    // Abort on entry 20 together with a valid entry.
    start(0);
    check("start_clears_bv", bv0, 4'b0000);
    s = str0;
    for (int i = 0; i < 20; i++) send(0, i, 3'(7 - i % 8), 0, 1'b0);
    v0 = 1'b1; dat0 = 3'd5; ab0 = 1'b1;
    tick();
    v0 = 1'b0; ab0 = 1'b0;
    check("abort_busy", busy0, 1'b0);
    check("abort_no_write", we0, 4'd0);
    tick();
    tick();
    check("abort_strobes", str0 - s, 20);
    check("abort_bv", bv0, 4'b0001);

    // Start during LOAD is ignored; a later start clears and reloads.
    start(0);
    for (int i = 0; i < 64; i++) begin
      send(0, i, 3'(i / 8), 0, (i == 10));
      if (i == 10) check("start_ignored_pulse", si0, 1'b1);
      if (i == 11) check("start_ignored_clear", si0, 1'b0);
    end
    tick();
    tick();
    check("restart1_bv", bv0, 4'b1111);
    check("restart1_done_count", dn0, 3);
    start(0);
    check("restart2_bv_cleared", bv0, 4'b0000);
    for (int i = 0; i < 64; i++) send(0, i, 3'(i + 5), 0, 1'b0);
    tick();
    tick();
    check("restart2_bv", bv0, 4'b1111);
    check("restart2_done_count", dn0, 4);

    // Small-geometry instance: 5 pages x 3 banks.
    start(1);
    s = str1;
    for (int i = 0; i < 15; i++) send(1, i, 3'(i % 8), 0, 1'b0);
    check("corner_bv_pre", bv1, 3'b011);
    tick();
    check("corner_done", done1, 1'b1);
    check("corner_bv", bv1, 3'b111);
    tick();
    tick();
    check("corner_strobes", str1 - s, 15);
    check("corner_done_count", dn1, 1);

    check("q0_drained", q0.size(), 0);
    check("q1_drained", q1.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
